maxnet_frame_loader: RTL and testbench
======================================

Name: maxnet_frame_loader

Overview:
Writer/initiator side of the Maxnet data-memory interface. It accepts a frame of N_WORDS 32-bit IEEE-754 words over a valid/ready input stream and writes them into the 4-entry data memory that the Maxnet datapath reads. It then pulses start, waits for done, captures the winning value, and presents it on a valid/ready result port. A watchdog flags a hung run.

Parameters:
N_WORDS, 4, words per frame; equals data-memory depth; address width clog2(N_WORDS)=2
TIMEOUT, 1024, max cycles in WAIT before error; counter width clog2(TIMEOUT+1)

Ports:
clk  input  1  rising-edge clock
rst  input  1  asynchronous reset, active-low
in_valid  input  1  input word valid
in_data  input  32  input word (IEEE-754 single)
in_ready  output  1  loader accepts word this cycle
mem_wr_en  output  1  data-memory write strobe
mem_wr_addr  output  2  data-memory write address
mem_wr_data  output  32  data-memory write data
mx_start  output  1  one-cycle start pulse to Maxnet controller
mx_done  input  1  Maxnet run complete (level or pulse)
mx_result  input  32  Maxnet max value, sampled when mx_done=1
res_valid  output  1  result available
res_data  output  32  captured result
res_ready  input  1  consumer takes result
busy  output  1  high in any state except LOAD
err_timeout  output  1  sticky watchdog flag; cleared by reset or next accepted word

Behaviour:
- Reset (rst=0, asynchronous): state=LOAD, word counter=0, watchdog=0. in_ready=1, mem_wr_en=0, mem_wr_addr=0, mem_wr_data=0, mx_start=0, res_valid=0, res_data=0, busy=0, err_timeout=0. Reset mid-frame discards partial frame; memory contents are not cleared.
- All outputs are registered.
- LOAD: in_ready=1. Handshake occurs on in_valid&in_ready at a clock edge. Next cycle: mem_wr_en=1, mem_wr_addr=counter, mem_wr_data=in_data; counter increments. Accepts back-to-back words at one per cycle. On acceptance of word N_WORDS-1, in_ready drops the next cycle and state goes to START. The counter wraps to 0.
- START: mx_start=1 for exactly one cycle, issued the cycle after the last memory write, so the write completes before the pulse. Go to WAIT and clear the watchdog.
- WAIT: in_ready=0. The watchdog increments each cycle.
  - mx_done=1: latch res_data=mx_result; res_valid=1 next cycle; go to RESULT.
  - Watchdog reaches TIMEOUT without done: err_timeout=1; go to LOAD. No result is produced.
  - Done on the same cycle the watchdog hits TIMEOUT: done wins; no error.
- RESULT: res_valid held until res_valid&res_ready. res_data is stable while valid. After the handshake, res_valid=0 next cycle and state goes to LOAD; in_ready=1 that same cycle.
- in_valid while not in LOAD is ignored and not consumed. mx_done outside WAIT is ignored.
- No arithmetic on data; words pass bit-exact (NaN/negatives unchanged).
- Latency: last input handshake at edge k → mem write visible cycle k+1 → mx_start cycle k+2 → res_valid one cycle after mx_done is sampled.

Test Plan:
- Reset values: hold rst=0 with random inputs → all outputs 0 except in_ready=1; release → LOAD.
- Back-to-back frame: 3F800000, 40000000, 40400000, 3F000000 with in_valid always 1 → writes addr 0..3 on consecutive cycles; in_ready=0 after 4th; single mx_start two cycles after 4th handshake.
- Gapped input with in_valid toggling → only handshaked words written; addresses 0,1,2,3 in order; no write on idle cycles.
- Result handshake: mx_done=1 with mx_result=40400000 → res_valid=1, res_data=40400000; hold res_ready=0 for 5 cycles → stable; res_ready=1 → res_valid=0 and in_ready=1 next cycle.
- Timeout: TIMEOUT=8, never assert mx_done → err_timeout=1 after 8 WAIT cycles, back in LOAD. Next accepted word clears err_timeout.
- Async reset mid-frame after 2 words → immediate return to reset values without waiting for a clock edge. New frame writes start at addr 0; no mx_start from the old frame.

Source files
------------

// File: rtl/maxnet_frame_loader.sv
// Loader for the Maxnet data memory. It writes one frame of words into memory,
// pulses start, then hands the winning value to a valid/ready result port.
module maxnet_frame_loader #(
  parameter int unsigned N_WORDS = 4,
  parameter int unsigned TIMEOUT = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  input  logic [31:0] in_data,
  output logic        in_ready,
  output logic        mem_wr_en,
  output logic [$clog2(N_WORDS)-1:0] mem_wr_addr,
  output logic [31:0] mem_wr_data,
  output logic        mx_start,
  input  logic        mx_done,
  input  logic [31:0] mx_result,
  output logic        res_valid,
  output logic [31:0] res_data,
  input  logic        res_ready,
  output logic        busy,
  output logic        err_timeout
);

  localparam int unsigned AW = $clog2(N_WORDS);
  localparam int unsigned WW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {StLoad, StStart, StWait, StResult} state_e;

  state_e          r_state, w_state_d;
  logic [AW-1:0]   r_cnt, w_cnt_d;
  logic [WW-1:0]   r_wd, w_wd_d, w_wd_inc;
  logic            r_in_ready, w_in_ready_d;
  logic            r_wr_en, w_wr_en_d;
  logic [AW-1:0]   r_wr_addr, w_wr_addr_d;
  logic [31:0]     r_wr_data, w_wr_data_d;
  logic            r_start, w_start_d;
  logic            r_res_valid, w_res_valid_d;
  logic [31:0]     r_res_data, w_res_data_d;
  logic            r_busy, w_busy_d;
  logic            r_err, w_err_d;

  assign w_wd_inc = r_wd + 1'b1;

  always_comb begin
    w_state_d     = r_state;
    w_cnt_d       = r_cnt;
    w_wd_d        = r_wd;
    w_in_ready_d  = r_in_ready;
    w_wr_en_d     = 1'b0;
    w_wr_addr_d   = r_wr_addr;
    w_wr_data_d   = r_wr_data;
    w_start_d     = 1'b0;
    w_res_valid_d = r_res_valid;
    w_res_data_d  = r_res_data;
    w_busy_d      = r_busy;
    w_err_d       = r_err;
    unique case (r_state)
      StLoad: begin
        if (in_valid && r_in_ready) begin
          w_wr_en_d   = 1'b1;
          w_wr_addr_d = r_cnt;
          w_wr_data_d = in_data;
          w_err_d     = 1'b0;
          if (r_cnt == AW'(N_WORDS - 1)) begin
            w_cnt_d      = '0;
            w_in_ready_d = 1'b0;
            w_busy_d     = 1'b1;
            w_state_d    = StStart;
          end else begin
            w_cnt_d = r_cnt + 1'b1;
          end
        end
      end
      // The last write is already on the memory port, so start trails it by one cycle.
      StStart: begin
        w_start_d = 1'b1;
        w_wd_d    = '0;
        w_state_d = StWait;
      end
      StWait: begin
        if (mx_done) begin
          w_res_data_d  = mx_result;
          w_res_valid_d = 1'b1;
          w_state_d     = StResult;
        end else if (w_wd_inc == WW'(TIMEOUT)) begin
          w_err_d      = 1'b1;
          w_in_ready_d = 1'b1;
          w_busy_d     = 1'b0;
          w_state_d    = StLoad;
        end else begin
          w_wd_d = w_wd_inc;
        end
      end
      StResult: begin
        if (r_res_valid && res_ready) begin
          w_res_valid_d = 1'b0;
          w_in_ready_d  = 1'b1;
          w_busy_d      = 1'b0;
          w_state_d     = StLoad;
        end
      end
      default: w_state_d = StLoad;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= StLoad;
      r_cnt       <= '0;
      r_wd        <= '0;
      r_in_ready  <= 1'b1;
      r_wr_en     <= 1'b0;
      r_wr_addr   <= '0;
      r_wr_data   <= '0;
      r_start     <= 1'b0;
      r_res_valid <= 1'b0;
      r_res_data  <= '0;
      r_busy      <= 1'b0;
      r_err       <= 1'b0;
    end else begin
      r_state     <= w_state_d;
      r_cnt       <= w_cnt_d;
      r_wd        <= w_wd_d;
      r_in_ready  <= w_in_ready_d;
      r_wr_en     <= w_wr_en_d;
      r_wr_addr   <= w_wr_addr_d;
      r_wr_data   <= w_wr_data_d;
      r_start     <= w_start_d;
      r_res_valid <= w_res_valid_d;
      r_res_data  <= w_res_data_d;
      r_busy      <= w_busy_d;
      r_err       <= w_err_d;
    end
  end

  assign in_ready    = r_in_ready;
  assign mem_wr_en   = r_wr_en;
  assign mem_wr_addr = r_wr_addr;
  assign mem_wr_data = r_wr_data;
  assign mx_start    = r_start;
  assign res_valid   = r_res_valid;
  assign res_data    = r_res_data;
  assign busy        = r_busy;
  assign err_timeout = r_err;

endmodule

// File: tb/tb_maxnet_frame_loader.sv
// Directed bench for maxnet_frame_loader: frame loading, start timing, result
// handshake, watchdog timeout and asynchronous reset.
module tb_maxnet_frame_loader;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic [31:0] in_data;
  logic        in_ready;
  logic        mem_wr_en;
  logic [1:0]  mem_wr_addr;
  logic [31:0] mem_wr_data;
  logic        mx_start;
  logic        mx_done;
  logic [31:0] mx_result;
  logic        res_valid;
  logic [31:0] res_data;
  logic        res_ready;
  logic        busy;
  logic        err_timeout;

  int n_tests = 0;
  int n_fail  = 0;

  maxnet_frame_loader #(
    .N_WORDS(4),
    .TIMEOUT(8)
  ) u_dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .in_ready   (in_ready),
    .mem_wr_en  (mem_wr_en),
    .mem_wr_addr(mem_wr_addr),
    .mem_wr_data(mem_wr_data),
    .mx_start   (mx_start),
    .mx_done    (mx_done),
    .mx_result  (mx_result),
    .res_valid  (res_valid),
    .res_data   (res_data),
    .res_ready  (res_ready),
    .busy       (busy),
    .err_timeout(err_timeout)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_cycle(input string tag);
    in_valid = 1'b0;
    tick();
    check(tag, {31'b0, mem_wr_en}, 32'd0);
  endtask

  task automatic send(input logic [1:0] a, input logic [31:0] d, input bit last);
    in_valid = 1'b1;
    in_data  = d;
    tick();
    in_valid = 1'b0;
    check("wr_en", {31'b0, mem_wr_en}, 32'd1);
    check("wr_addr", {30'b0, mem_wr_addr}, {30'b0, a});
    check("wr_data", mem_wr_data, d);
    check("in_ready", {31'b0, in_ready}, {31'b0, !last});
  endtask

  // Checks the start pulse after the last handshake; leaves time at cycle k+2.
  task automatic expect_start();
    check("start_k1", {31'b0, mx_start}, 32'd0);
    check("busy_k1", {31'b0, busy}, 32'd1);
    tick();
    check("start_k2", {31'b0, mx_start}, 32'd1);
    check("wr_en_k2", {31'b0, mem_wr_en}, 32'd0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_in_ready"}, {31'b0, in_ready}, 32'd1);
    check({tag, "_wr_en"}, {31'b0, mem_wr_en}, 32'd0);
    check({tag, "_wr_addr"}, {30'b0, mem_wr_addr}, 32'd0);
    check({tag, "_wr_data"}, mem_wr_data, 32'd0);
    check({tag, "_start"}, {31'b0, mx_start}, 32'd0);
    check({tag, "_res_valid"}, {31'b0, res_valid}, 32'd0);
    check({tag, "_res_data"}, res_data, 32'd0);
    check({tag, "_busy"}, {31'b0, busy}, 32'd0);
    check({tag, "_err"}, {31'b0, err_timeout}, 32'd0);
  endtask

  logic [31:0] frame_a [4] = '{32'h3F800000, 32'h40000000, 32'h40400000, 32'h3F000000};
  logic [31:0] frame_b [4] = '{32'h7FC00001, 32'hBF800000, 32'h00000000, 32'hFF800000};

  initial begin
    rst       = 1'b0;
    in_valid  = 1'b1;
    in_data   = $urandom;
    mx_done   = 1'b1;
    mx_result = $urandom;
    res_ready = 1'b1;
    repeat (3) tick();
    check_reset_outputs("rst");
    in_valid  = 1'b0;
    mx_done   = 1'b0;
    res_ready = 1'b0;
    rst       = 1'b1;
    tick();
    check("post_rst_in_ready", {31'b0, in_ready}, 32'd1);

    // Back-to-back frame
    for (int i = 0; i < 4; i++) send(2'(i), frame_a[i], i == 3);
    expect_start();
    tick();
    check("start_once", {31'b0, mx_start}, 32'd0);

    // Result handshake; in_valid during WAIT/RESULT must be ignored
    in_valid  = 1'b1;
    in_data   = 32'hDEADBEEF;
    mx_done   = 1'b1;
    mx_result = 32'h40400000;
    tick();
    mx_done   = 1'b0;
    mx_result = 32'h12345678;
    check("res_valid", {31'b0, res_valid}, 32'd1);
    check("res_data", res_data, 32'h40400000);
    check("res_in_ready", {31'b0, in_ready}, 32'd0);
    for (int i = 0; i < 5; i++) begin
      tick();
      check("res_hold_valid", {31'b0, res_valid}, 32'd1);
      check("res_hold_data", res_data, 32'h40400000);
      check("res_no_write", {31'b0, mem_wr_en}, 32'd0);
    end
    in_valid  = 1'b0;
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
    check("res_drop", {31'b0, res_valid}, 32'd0);
    check("res_in_ready_back", {31'b0, in_ready}, 32'd1);
    check("res_busy", {31'b0, busy}, 32'd0);

    // Gapped frame with bit-exact NaN/negative words
    for (int i = 0; i < 4; i++) begin
      idle_cycle("gap_no_write");
      send(2'(i), frame_b[i], i == 3);
    end
    expect_start();

    // Timeout: no done; 8 WAIT cycles starting at the start-pulse cycle
    repeat (7) tick();
    check("wd_not_yet", {31'b0, err_timeout}, 32'd0);
    tick();
    check("wd_err", {31'b0, err_timeout}, 32'd1);
    check("wd_in_ready", {31'b0, in_ready}, 32'd1);
    check("wd_busy", {31'b0, busy}, 32'd0);
    check("wd_no_result", {31'b0, res_valid}, 32'd0);
    tick();
    check("wd_sticky", {31'b0, err_timeout}, 32'd1);

    // Next accepted word clears the flag; done on the timeout cycle wins
    send(2'd0, frame_a[0], 1'b0);
    check("err_cleared", {31'b0, err_timeout}, 32'd0);
    for (int i = 1; i < 4; i++) send(2'(i), frame_a[i], i == 3);
    expect_start();
    repeat (7) tick();
    mx_done   = 1'b1;
    mx_result = 32'hC0A00000;
    tick();
    mx_done = 1'b0;
    check("race_res_valid", {31'b0, res_valid}, 32'd1);
    check("race_res_data", res_data, 32'hC0A00000);
    check("race_no_err", {31'b0, err_timeout}, 32'd0);
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
    check("race_back_load", {31'b0, in_ready}, 32'd1);

    // Asynchronous reset mid-frame, between clock edges
    send(2'd0, 32'h11111111, 1'b0);
    send(2'd1, 32'h22222222, 1'b0);
    #2;
    rst = 1'b0;
    #1;
    check_reset_outputs("async");
    tick();
    rst = 1'b1;
    tick();
    check("async_no_start", {31'b0, mx_start}, 32'd0);
    for (int i = 0; i < 4; i++) begin
      send(2'(i), frame_b[i], i == 3);
      if (i < 3) check("async_frame_no_start", {31'b0, mx_start}, 32'd0);
    end
    expect_start();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
